// File: rtl/md_hilo_ctrl.sv
// EX-stage multiply/divide sequencer: launches the mul/div units, stalls EX while
// an operation is in flight, and owns the HI/LO architectural registers.
module md_hilo_ctrl #(
   parameter int unsigned MUL_LAT    = 2,
   parameter logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        ex_hold,
   input  logic        op_valid,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        mul_signed,
   output logic [31:0] mul_ina,
   output logic [31:0] mul_inb,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_opa,
   output logic [31:0] div_opb,
   output logic        div_annul,
   input  logic        div_ready,
   input  logic [63:0] div_result,
   output logic        stallreq,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;

   logic go;
   logic is_mul;
   logic is_div;

   assign go     = op_valid & ~flush;
   assign is_mul = (md_op == OP_MULT) | (md_op == OP_MULTU);
   assign is_div = (md_op == OP_DIV)  | (md_op == OP_DIVU);

   // Operands are pass-through; EX keeps them stable while stalled.
   assign mul_ina = src_a;
   assign mul_inb = src_b;
   assign div_opa = src_a;
   assign div_opb = src_b;
   assign hi      = hi_q;
   assign lo      = lo_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      mul_signed = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      div_annul  = 1'b0;
      stallreq   = 1'b0;

      if (rst) begin
         state_d = S_IDLE;
      end else if (flush) begin
         // Flush wins over any completion in the same cycle.
         state_d   = S_IDLE;
         div_annul = (state_q == S_DIV);
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (go) begin
                  stallreq = is_mul | is_div;
                  if (is_mul) begin
                     state_d = S_MUL;
                     cnt_d   = CNT_W'(MUL_LAT - 1);
                  end else if (is_div) begin
                     if (src_b == 32'd0) begin
                        state_d = S_DONE;
                        hi_d    = src_a;
                        lo_d    = DIVZERO_LO;
                     end else begin
                        state_d = S_DIV;
                     end
                  end else if (md_op == OP_MTHI) begin
                     hi_d = src_a;
                  end else if (md_op == OP_MTLO) begin
                     lo_d = src_a;
                  end
               end
            end
            S_MUL: begin
               stallreq   = 1'b1;
               mul_signed = (md_op == OP_MULT);
               if (cnt_q == '0) begin
                  hi_d    = mul_result[63:32];
                  lo_d    = mul_result[31:0];
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_DIV: begin
               stallreq   = 1'b1;
               div_signed = (md_op != OP_DIVU);
               if (div_ready) begin
                  hi_d    = div_result[63:32];
                  lo_d    = div_result[31:0];
                  state_d = S_DONE;
               end else begin
                  div_start = 1'b1;
               end
            end
            S_DONE: begin
               // A held instruction keeps op_valid up; don't relaunch it.
               if (!ex_hold) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Scoreboard bench for md_hilo_ctrl with behavioural mul and iterative-div models.
module tb_md_hilo_ctrl;

   localparam int unsigned MUL_LAT = 2;
   localparam int unsigned DIV_LAT = 33;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        ex_hold;
   logic        op_valid;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        mul_signed;
   logic [31:0] mul_ina;
   logic [31:0] mul_inb;
   logic [63:0] mul_result;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_opa;
   logic [31:0] div_opb;
   logic        div_annul;
   logic        div_ready;
   logic [63:0] div_result;
   logic        stallreq;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [63:0] hilo;
      logic [7:0]  stalls;
      logic        started;
      logic        sgn;
   } exp_t;

   exp_t exp_q[$];

   md_hilo_ctrl #(.MUL_LAT(MUL_LAT), .DIVZERO_LO(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold),
      .op_valid(op_valid), .md_op(md_op), .src_a(src_a), .src_b(src_b),
      .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
      .mul_result(mul_result),
      .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa),
      .div_opb(div_opb), .div_annul(div_annul), .div_ready(div_ready),
      .div_result(div_result),
      .stallreq(stallreq), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Multiplier model: product of the presented operands.
   logic [63:0] sa, sb;
   always_comb begin
      sa = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'd0, mul_ina};
      sb = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'd0, mul_inb};
      mul_result = sa * sb;
   end

   // Divider model: ready after DIV_LAT start cycles; annul restarts it.
   int dcnt;
   always @(posedge clk) begin
      if (rst || div_annul || div_ready) dcnt <= 0;
      else if (div_start)                dcnt <= dcnt + 1;
   end
   assign div_ready = (dcnt == DIV_LAT);

   always_comb begin
      if (div_opb == 32'd0)
         div_result = 64'd0;
      else if (div_signed)
         div_result = {32'($signed(div_opa) % $signed(div_opb)),
                       32'($signed(div_opa) / $signed(div_opb))};
      else
         div_result = {div_opa % div_opb, div_opa / div_opb};
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch one mul/div op, run it to DONE, compare against the scoreboard head.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int unsigned stalls, input logic started, input logic sgn,
                         input logic [63:0] hilo, input int hold);
      exp_t e;
      int   n_st;
      logic seen_start, seen_sgn, done;
      exp_q.push_back('{hilo: hilo, stalls: 8'(stalls), started: started, sgn: sgn});
      @(negedge clk);
      op_valid = 1'b1; md_op = op; src_a = a; src_b = b;
      #1;
      check("launch_stall", 64'(stallreq), 64'd1);
      n_st = 0; seen_start = 1'b0; seen_sgn = 1'b0; done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!stallreq) done = 1'b1;
         else begin
            n_st++;
            seen_start = seen_start | div_start;
            seen_sgn   = seen_sgn | mul_signed | div_signed;
            if (div_start) check("div_start_nonzero_divisor", 64'(div_opb != 0), 64'd1);
         end
      end
      check("op_completes", 64'(done), 64'd1);
      e = exp_q.pop_front();
      check("hilo",      {hi, lo}, e.hilo);
      check("stalls",    64'(n_st), 64'(e.stalls));
      check("div_start", 64'(seen_start), 64'(e.started));
      check("signed",    64'(seen_sgn), 64'(e.sgn));
      if (hold > 0) begin
         ex_hold = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_no_relaunch", 64'(stallreq), 64'd0);
            check("hold_hilo", {hi, lo}, e.hilo);
         end
      end
      ex_hold = 1'b0; op_valid = 1'b0; md_op = OP_NONE;
      @(negedge clk);
      check("idle_after", 64'(stallreq), 64'd0);
   endtask

   logic [63:0] saved;

   initial begin
      rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
      op_valid = 1'b1; md_op = OP_MULT; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
      repeat (2) @(negedge clk);
      check("rst_stall",   64'(stallreq), 64'd0);
      check("rst_hilo",    {hi, lo}, 64'd0);
      check("rst_ctrl",    64'({mul_signed, div_start, div_signed, div_annul}), 64'd0);
      check("rst_mul_ops", {mul_ina, mul_inb}, 64'hDEAD_BEEF_1234_5678);
      check("rst_div_ops", {div_opa, div_opb}, 64'hDEAD_BEEF_1234_5678);
      rst = 1'b0; op_valid = 1'b0; md_op = OP_NONE;
      @(negedge clk);

      run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, MUL_LAT, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0);
      run_op(OP_MULTU, 32'hFFFF_FFFD, 32'd7, MUL_LAT, 1'b0, 1'b0, 64'h0000_0006_FFFF_FFEB, 0);
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, DIV_LAT + 1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 0);
      run_op(OP_DIVU,  32'hFFFF_FFF9, 32'd2, DIV_LAT + 1, 1'b1, 1'b0, 64'h0000_0001_7FFF_FFFC, 0);
      run_op(OP_DIVU,  32'd100,       32'd7, DIV_LAT + 1, 1'b1, 1'b0, 64'h0000_0002_0000_000E, 0);
      run_op(OP_DIVU,  32'd5,         32'd0, 0,           1'b0, 1'b0, 64'h0000_0005_FFFF_FFFF, 0);

      // MTHI then MTLO back to back: no stall, each visible the following cycle.
      @(negedge clk);
      op_valid = 1'b1; md_op = OP_MTHI; src_a = 32'h0000_1234;
      #1 check("mthi_stall", 64'(stallreq), 64'd0);
      @(negedge clk);
      md_op = OP_MTLO; src_a = 32'h0000_ABCD;
      #1 check("mtlo_stall", 64'(stallreq), 64'd0);
      check("mthi_hi", 64'(hi), 64'h1234);
      @(negedge clk);
      op_valid = 1'b0; md_op = OP_NONE;
      check("mtlo_hilo", {hi, lo}, 64'h0000_1234_0000_ABCD);

      // Flush a divide mid-flight.
      saved = {hi, lo};
      @(negedge clk);
      op_valid = 1'b1; md_op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
      repeat (10) @(negedge clk);
      check("div_busy", 64'({stallreq, div_start}), 64'h3);
      flush = 1'b1;
      #1;
      check("flush_annul", 64'(div_annul), 64'd1);
      check("flush_stall", 64'(stallreq), 64'd0);
      @(negedge clk);
      flush = 1'b0; op_valid = 1'b0; md_op = OP_NONE;
      #1;
      check("post_flush_ctrl", 64'({div_annul, div_start, stallreq}), 64'd0);
      check("post_flush_hilo", {hi, lo}, saved);

      run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, DIV_LAT + 1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 0);
      run_op(OP_MULT, 32'd4,         32'd5, MUL_LAT,     1'b0, 1'b1, 64'h0000_0000_0000_0014, 3);

      // Reset in the middle of a divide.
      @(negedge clk);
      op_valid = 1'b1; md_op = OP_DIVU; src_a = 32'd77; src_b = 32'd5;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_hilo", {hi, lo}, 64'd0);
      check("midrst_ctrl", 64'({div_start, stallreq}), 64'd0);
      rst = 1'b0; op_valid = 1'b0; md_op = OP_NONE;
      @(negedge clk);
      check("midrst_idle", 64'(stallreq), 64'd0);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
